alu_nbit_seq: RTL and testbench
===============================

// Module: alu_nbit_seq
// PURPOSE
//   Parametrised, registered successor to the 4-bit combinational ALU slices (XOR/AND/OR/ADD).
//   Takes signed WIDTH-bit operands and a 3-bit opcode through a start/busy/done handshake.
//   Returns a registered result and status flags.
//   Logic and arithmetic ops complete in 1 cycle; the optional multiply is a WIDTH-cycle shift-add.
//   Sits between the lab register file/control FSM and the display/result latch.
// PARAMETERS
//   WIDTH   4   operand/result width in bits, two's complement; legal range 2..32
// PORTS
//   clk     in   1      single clock, all state updates on rising edge
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; sampled only when busy==0
//   op      in   3      opcode, sampled with start
//   in1     in   WIDTH  signed operand A, sampled with start
//   in2     in   WIDTH  signed operand B, sampled with start
//   result  out  WIDTH  registered result; holds until next completion
//   busy    out  1      high while a multi-cycle op is in progress
//   done    out  1      one-cycle pulse: result/flags updated this cycle
//   zero    out  1      result == 0
//   neg     out  1      result[WIDTH-1]
//   carry   out  1      carry-out (ADD/SUB only, else 0)
//   ovf     out  1      signed overflow (ADD/SUB only, else 0)
//   err     out  1      illegal/disabled opcode
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous): all outputs 0; FSM -> IDLE; any multiply in flight is aborted.
//   - Opcodes:
//       000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (in1-in2), 101 SLT (signed, result = 0 or 1),
//       110 MUL (low WIDTH bits of the product), 111 reserved.
//   - ADD/SUB are computed as in1 + (in2 or ~in2) + (0 or 1).
//       carry = bit WIDTH of that sum.
//       ovf = operand signs equal (after inversion) and result sign differs.
//   - SLT: carry = ovf = 0.
//   - FSM has two states: IDLE and MUL.
//   - IDLE:
//       start=1 with op!=110 -> at the next edge, result/flags/err update and done=1; stay in IDLE.
//       start=1 with op==110 -> latch operands, counter = 0, busy=1 at the next edge, go to MUL.
//   - MUL:
//       one shift-add step per cycle.
//       After WIDTH steps: result/flags update, done=1, busy=0, back to IDLE.
//       start is ignored while busy=1 (no queueing).
//   - Latency from the edge that samples start:
//       single-cycle ops: 1 cycle.
//       MUL: WIDTH+1 cycles; busy is high for exactly WIDTH cycles.
//   - Back-to-back: start is accepted in the same cycle done is high (busy=0), giving 1 op/cycle throughput.
//   - MUL arithmetic:
//       unsigned shift-add on the bit patterns; the low WIDTH bits equal the signed product.
//       carry = ovf = 0 (truncation is not flagged).
//   - err=1 for op 111, and for op 110 when the multiplier is compiled out.
//       In that case: result=0, zero=1, other flags 0, done pulses with 1-cycle latency.
//       err clears on the next legal completion.
//   - Flags are registered with result and hold until the next done.
// CONFIGURATION
//   ALU_MUL_EN defined:
//     MUL opcode and MUL state are present as described above.
//   ALU_MUL_EN undefined:
//     no multiplier logic or counter is built; busy is tied to 0.
//     op 110 behaves as illegal (err=1, 1-cycle done).
// TESTING (WIDTH=4, ALU_MUL_EN defined unless stated)
//   1. Reset mid-MUL:
//        start MUL, pull rst_n low after 2 cycles -> result=0000, busy=0, done=0, all flags 0.
//        The next start then completes normally.
//   2. XOR:
//        in1=1111, in2=1111 -> result=0000, zero=1, done after 1 cycle.
//        in1=1011, in2=0011 -> result=1000, neg=1.
//   3. ADD overflow:
//        0111 + 0001 -> result=1000, ovf=1, neg=1, carry=0.
//        SUB 0000 - 0001 -> result=1111, carry=0, ovf=0.
//   4. MUL:
//        1101 (-3) * 0010 -> busy high 4 cycles, done at cycle 5, result=1010 (-6).
//        A start issued while busy is ignored (no extra done).
//   5. Back-to-back: AND then OR on consecutive cycles -> two consecutive done pulses, correct results.
//   6. Illegal op:
//        op=111 -> err=1, result=0000, zero=1.
//        With ALU_MUL_EN undefined, op=110 gives the same response and busy stays 0.

Source files
------------

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: registered WIDTH-bit signed ALU with a start/busy/done handshake.
// Ops: AND, OR, XOR, ADD, SUB, SLT complete in one cycle; MUL is a WIDTH-step shift-add.
// Build option: define ALU_MUL_EN to include the multiplier; without it, op 110 reports err.
module alu_nbit_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`endif

  logic [WIDTH-1:0] result_q;
  logic             done_q, zero_q, neg_q, carry_q, ovf_q, err_q;

  logic [WIDTH-1:0] opb_c;
  logic             cin_c;
  logic [SUM_W-1:0] sum_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c, ovf_c, err_c;

  // Single-cycle datapath: ADD/SUB share one adder via optional inversion of in2
  always_comb begin
    opb_c   = in2;
    cin_c   = 1'b0;
    if (op == OP_SUB) begin
      opb_c = ~in2;
      cin_c = 1'b1;
    end
    sum_c   = {1'b0, in1} + {1'b0, opb_c} + SUM_W'(cin_c);
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    err_c   = 1'b0;
    case (op)
      OP_AND: res_c = in1 & in2;
      OP_OR:  res_c = in1 | in2;
      OP_XOR: res_c = in1 ^ in2;
      OP_ADD, OP_SUB: begin
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
        ovf_c   = (in1[WIDTH-1] == opb_c[WIDTH-1]) && (sum_c[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLT: res_c = WIDTH'($signed(in1) < $signed(in2));
      default: err_c = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [WIDTH-1:0] acc_d;

  // One shift-add step: accumulate the shifted multiplicand when the multiplier LSB is set
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && (op == OP_MUL)) begin
            state_q  <= S_MUL;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= in1;
            mplier_q <= in2;
          end else if (start) begin
            result_q <= res_c;
            zero_q   <= (res_c == '0);
            neg_q    <= res_c[WIDTH-1];
            carry_q  <= carry_c;
            ovf_q    <= ovf_c;
            err_q    <= err_c;
            done_q   <= 1'b1;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_q <= acc_d;
            zero_q   <= (acc_d == '0);
            neg_q    <= acc_d[WIDTH-1];
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
`else
  // Registered outputs; every accepted request completes in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        result_q <= res_c;
        zero_q   <= (res_c == '0);
        neg_q    <= res_c[WIDTH-1];
        carry_q  <= carry_c;
        ovf_q    <= ovf_c;
        err_q    <= err_c;
        done_q   <= 1'b1;
      end
    end
  end

  assign busy = 1'b0;
`endif

  assign result = result_q;
  assign done   = done_q;
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign carry  = carry_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb_alu_nbit_seq: directed vectors for alu_nbit_seq (WIDTH=4) checked against an
// arithmetic reference model every cycle, plus hand-computed literal expectations.
module tb_alu_nbit_seq;

  localparam int unsigned W = 4;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] in1, in2;
  logic [W-1:0] result;
  logic         busy, done, zero, neg, carry, ovf, err;

  int n_chk  = 0;
  int n_fail = 0;
  bit running = 1'b1;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
    .result(result), .busy(busy), .done(done), .zero(zero), .neg(neg),
    .carry(carry), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: outputs of one operation from plain integer arithmetic
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   x;
    longint ua, ub, sa, sb, s, full;
    longint lim_hi, lim_lo;
    x      = '0;
    ua     = longint'(a);
    ub     = longint'(b);
    sa     = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb     = b[W-1] ? ub - (longint'(1) << W) : ub;
    lim_hi = (longint'(1) << (W - 1)) - 1;
    lim_lo = -(longint'(1) << (W - 1));
    case (o)
      3'd0: x.r = a & b;
      3'd1: x.r = a | b;
      3'd2: x.r = a ^ b;
      3'd3: begin
        full = ua + ub;
        x.r  = W'(full);
        x.c  = (full >= (longint'(1) << W));
        s    = sa + sb;
        x.v  = (s > lim_hi) || (s < lim_lo);
      end
      3'd4: begin
        x.r = W'(ua - ub);
        x.c = (ua >= ub);
        s   = sa - sb;
        x.v = (s > lim_hi) || (s < lim_lo);
      end
      3'd5: x.r = (sa < sb) ? W'(1) : W'(0);
      3'd6: begin
        if (MUL_EN) x.r = W'(ua * ub);
        else        x.e = 1'b1;
      end
      default: x.e = 1'b1;
    endcase
    x.z = (x.r == '0);
    x.n = x.r[W-1];
    return x;
  endfunction

  // Cycle model: expected registered outputs, busy window and done pulses
  exp_t m_out, m_mul;
  logic m_busy, m_done;
  int   m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out  <= '0;
      m_mul  <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_out  <= m_mul;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (start) begin
        if (op == 3'b110 && MUL_EN) begin
          m_left <= W;
          m_busy <= 1'b1;
          m_mul  <= model(op, in1, in2);
        end else begin
          m_out  <= model(op, in1, in2);
          m_done <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (running) begin
      n_chk++;
      if ({result, busy, done, zero, neg, carry, ovf, err} !==
          {m_out.r, m_busy, m_done, m_out.z, m_out.n, m_out.c, m_out.v, m_out.e}) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got r=%b busy=%b done=%b z=%b n=%b c=%b v=%b e=%b, want r=%b busy=%b done=%b z=%b n=%b c=%b v=%b e=%b",
                 $time, result, busy, done, zero, neg, carry, ovf, err,
                 m_out.r, m_busy, m_done, m_out.z, m_out.n, m_out.c, m_out.v, m_out.e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #2;
    start = s;
    op    = o;
    in1   = a;
    in2   = b;
  endtask

  // One request pulse; returns on the negedge after the sampling edge
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    drive(1'b1, o, a, b);
    drive(1'b0, o, a, b);
    @(negedge clk);
  endtask

  logic [W-1:0] va [4] = '{4'h5, 4'h8, 4'h7, 4'h9};
  logic [W-1:0] vb [4] = '{4'h3, 4'h8, 4'hF, 4'h6};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    in1   = '0;
    in2   = '0;

    // Model pins
    chk("model_add_ovf", 32'(model(3'd3, 4'b0111, 4'b0001)), 32'b1000_0_1_0_1_0);
    chk("model_sub_neg", 32'(model(3'd4, 4'b0000, 4'b0001)), 32'b1111_0_1_0_0_0);
    chk("model_mul", 32'(model(3'd6, 4'b1101, 4'b0010)),
        MUL_EN ? 32'b1010_0_1_0_0_0 : 32'b0000_1_0_0_0_1);

    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({result, busy, done, zero, neg, carry, ovf, err}), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    do_op(3'b010, 4'b1111, 4'b1111);
    chk("xor_same_r", 32'(result), 32'h0);
    chk("xor_same_zero", 32'(zero), 32'h1);
    chk("xor_same_done", 32'(done), 32'h1);
    do_op(3'b010, 4'b1011, 4'b0011);
    chk("xor_r", 32'(result), 32'b1000);
    chk("xor_neg", 32'(neg), 32'h1);

    do_op(3'b011, 4'b0111, 4'b0001);
    chk("add_ovf_flags", 32'({result, ovf, neg, carry}), 32'b1000_1_1_0);
    do_op(3'b100, 4'b0000, 4'b0001);
    chk("sub_borrow", 32'({result, carry, ovf}), 32'b1111_0_0);
    do_op(3'b011, 4'b1111, 4'b0001);
    chk("add_carry", 32'({result, carry, zero, ovf}), 32'b0000_1_1_0);
    do_op(3'b100, 4'b0101, 4'b0011);
    chk("sub_nb", 32'({result, carry}), 32'b0010_1);
    do_op(3'b101, 4'b1110, 4'b0001);
    chk("slt_true", 32'(result), 32'h1);
    do_op(3'b101, 4'b0001, 4'b1110);
    chk("slt_false", 32'({result, zero}), 32'b0000_1);

    // Back-to-back AND then OR
    drive(1'b1, 3'b000, 4'b1100, 4'b1010);
    drive(1'b1, 3'b001, 4'b1100, 4'b1010);
    @(negedge clk);
    chk("b2b_and", 32'({result, done}), 32'b1000_1);
    drive(1'b0, 3'b001, 4'b1100, 4'b1010);
    @(negedge clk);
    chk("b2b_or", 32'({result, done}), 32'b1110_1);

    // Illegal op, then a legal op clears err
    do_op(3'b111, 4'b0110, 4'b0101);
    chk("illegal", 32'({result, zero, err, done}), 32'b0000_1_1_1);
    do_op(3'b000, 4'b0110, 4'b0101);
    chk("err_clear", 32'({result, err}), 32'b0100_0);

    // MUL -3 * 2, with a start issued while busy
    do_op(3'b110, 4'b1101, 4'b0010);
    chk("mul_c1_busy", 32'(busy), 32'(MUL_EN));
    drive(1'b1, 3'b011, 4'b0001, 4'b0001);
    @(negedge clk);
    chk("mul_c2_busy", 32'(busy), 32'(MUL_EN));
    drive(1'b0, 3'b011, 4'b0001, 4'b0001);
    drive(1'b0, 3'b011, 4'b0001, 4'b0001);
    @(negedge clk);
    chk("mul_c4_busy", 32'(busy), 32'(MUL_EN));
    drive(1'b0, 3'b011, 4'b0001, 4'b0001);
    @(negedge clk);
    chk("mul_c5", 32'({result, busy, done, err}),
        MUL_EN ? 32'b1010_0_1_0 : 32'b0010_0_0_0);
    drive(1'b0, 3'b011, 4'b0001, 4'b0001);
    @(negedge clk);
    chk("mul_no_extra_done", 32'(done), 32'h0);

    // Reset in the middle of a multiply
    drive(1'b1, 3'b110, 4'b0011, 4'b0011);
    drive(1'b0, 3'b110, 4'b0011, 4'b0011);
    drive(1'b0, 3'b110, 4'b0011, 4'b0011);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_mul", 32'({result, busy, done, zero, neg, carry, ovf, err}), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_op(3'b000, 4'b0110, 4'b0011);
    chk("after_reset_and", 32'({result, done, busy}), 32'b0010_1_0);

    // Sweep all opcodes over a few operand pairs, checked by the model
    for (int o = 0; o < 8; o++) begin
      for (int k = 0; k < 4; k++) begin
        do_op(3'(o), va[k], vb[k]);
        if (o == 6) repeat (W + 1) drive(1'b0, 3'(o), va[k], vb[k]);
      end
    end
    repeat (2) @(negedge clk);

    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
